noc_pkt_tx: RTL and testbench



---
 rtl/noc_pkg.sv | 37 +++
 rtl/noc_out_reg.sv | 32 +++
 rtl/noc_pkt_tx.sv | 102 ++++++++++
 tb/tb_noc_pkt_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: flit types, head-flit field layout, TX FSM states.
// Used by both the packet transmitter and the packet receiver.
package noc_pkg;

   localparam int FLIT_DATA_W = 32;
   localparam int FLIT_TYPE_W = 2;
   localparam int FLIT_W      = FLIT_TYPE_W + FLIT_DATA_W;

   typedef enum logic [1:0] {
      FT_PAYLOAD = 2'b00,
      FT_HEAD    = 2'b01,
      FT_LAST    = 2'b10,
      FT_SINGLE  = 2'b11
   } flit_type_e;

   localparam int HDR_DEST_LSB  = 27;
   localparam int HDR_CLASS_LSB = 24;
   localparam int HDR_SRC_LSB   = 19;

   typedef enum logic {
      ST_IDLE,
      ST_PAYLOAD
   } tx_state_e;

   // Head content: dest, class, source; low bits reserved as zero.
   function automatic logic [FLIT_DATA_W-1:0] make_head(input logic [4:0] dest,
                                                        input logic [2:0] cls,
                                                        input logic [4:0] src);
      logic [FLIT_DATA_W-1:0] h;
      h = '0;
      h[HDR_DEST_LSB  +: 5] = dest;
      h[HDR_CLASS_LSB +: 3] = cls;
      h[HDR_SRC_LSB   +: 5] = src;
      return h;
   endfunction

endpackage

// File: rtl/noc_out_reg.sv
// One-entry registered flit output stage; accepts a new flit whenever empty
// or when the current flit is being taken by the router in the same cycle.
module noc_out_reg
   import noc_pkg::*;
#(
   parameter int W = FLIT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         noc_ready,
   output logic         can_load,
   output logic [W-1:0] noc_flit,
   output logic         noc_valid
);

   assign can_load = !noc_valid || noc_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         noc_valid <= 1'b0;
         noc_flit  <= '0;
      end else if (load) begin
         noc_valid <= 1'b1;
         noc_flit  <= din;
      end else if (noc_ready) begin
         noc_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/noc_pkt_tx.sv
// NoC packet transmitter: turns a (dest, class, len) request plus payload words
// into HEAD/PAYLOAD/LAST or SINGLE flits through a registered output stage.
module noc_pkt_tx
   import noc_pkg::*;
#(
   parameter int         FLIT_DATA_WIDTH = FLIT_DATA_W,
   parameter int         FLIT_TYPE_WIDTH = FLIT_TYPE_W,
   parameter int         MAX_LEN         = 16,
   parameter logic [4:0] SRC_ID          = 5'd0,
   parameter int         LEN_WIDTH       = $clog2(MAX_LEN + 1)
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     req_valid,
   output logic                                     req_ready,
   input  logic [4:0]                               req_dest,
   input  logic [2:0]                               req_class,
   input  logic [LEN_WIDTH-1:0]                     req_len,
   input  logic                                     word_valid,
   output logic                                     word_ready,
   input  logic [FLIT_DATA_WIDTH-1:0]               word_data,
   output logic [FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH-1:0] noc_flit,
   output logic                                     noc_valid,
   input  logic                                     noc_ready,
   output logic                                     busy,
   output logic                                     err_len
);

   localparam int                 FW        = FLIT_TYPE_WIDTH + FLIT_DATA_WIDTH;
   localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);

   tx_state_e            state;
   logic [LEN_WIDTH-1:0] remaining;
   logic                 can_load;
   logic                 req_hs;
   logic                 word_hs;
   logic                 too_long;
   logic                 load;
   logic [FW-1:0]        flit_d;
   flit_type_e           ftype;

   // Ready gated by rst so nothing is handshaken in the reset cycle.
   assign req_ready  = !rst && (state == ST_IDLE)    && can_load;
   assign word_ready = !rst && (state == ST_PAYLOAD) && can_load;
   assign req_hs     = req_valid  && req_ready;
   assign word_hs    = word_valid && word_ready;
   assign too_long   = req_len > MAX_LEN_L;
   assign busy       = (state != ST_IDLE) || noc_valid;

   always_comb begin
      load   = 1'b0;
      flit_d = '0;
      ftype  = FT_PAYLOAD;
      if (req_hs && !too_long) begin
         load   = 1'b1;
         ftype  = (req_len == '0) ? FT_SINGLE : FT_HEAD;
         flit_d = {ftype, make_head(req_dest, req_class, SRC_ID)};
      end else if (word_hs) begin
         load   = 1'b1;
         ftype  = (remaining == ONE) ? FT_LAST : FT_PAYLOAD;
         flit_d = {ftype, word_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         err_len   <= 1'b0;
      end else begin
         err_len <= req_hs && too_long;
         case (state)
            ST_IDLE: begin
               if (req_hs && !too_long && (req_len != '0)) begin
                  remaining <= req_len;
                  state     <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (word_hs) begin
                  remaining <= remaining - ONE;
                  if (remaining == ONE) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   noc_out_reg #(.W(FW)) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .din       (flit_d),
      .noc_ready (noc_ready),
      .can_load  (can_load),
      .noc_flit  (noc_flit),
      .noc_valid (noc_valid)
   );

endmodule

// File: tb/tb_noc_pkt_tx.sv
// Bench for noc_pkt_tx: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a packet-level flit queue model.
module tb_noc_pkt_tx;

   localparam int         MAX_LEN = 16;
   localparam int         LW      = 5;
   localparam logic [4:0] SRC     = 5'd5;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready;
   logic [4:0]    req_dest;
   logic [2:0]    req_class;
   logic [LW-1:0] req_len;
   logic          word_valid, word_ready;
   logic [31:0]   word_data;
   logic [33:0]   noc_flit;
   logic          noc_valid, noc_ready;
   logic          busy, err_len;

   noc_pkt_tx #(.MAX_LEN(MAX_LEN), .SRC_ID(SRC)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_dest   (req_dest),
      .req_class  (req_class),
      .req_len    (req_len),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .noc_flit   (noc_flit),
      .noc_valid  (noc_valid),
      .noc_ready  (noc_ready),
      .busy       (busy),
      .err_len    (err_len)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [33:0] head(input logic [1:0] t, input logic [4:0] d, input logic [2:0] c);
      return {t, d, c, SRC, 19'b0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // noc_ready policy used by the randomized driver: 0 always, 1 toggle, 2 random
   int rmode = 0;
   task automatic step_r();
      @(posedge clk);
      #1;
      case (rmode)
         1:       noc_ready = !noc_ready;
         2:       noc_ready = ($urandom_range(0, 3) != 0);
         default: noc_ready = 1'b1;
      endcase
   endtask

   // ---------------- packet-level reference model + monitor ----------------
   logic [33:0] exp_q[$];
   int          exp_err = 0;
   int          obs_err = 0;
   logic        mon_en  = 1'b0;
   logic        stall_prev = 1'b0;
   logic [33:0] prev_flit;

   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_prev) begin
            chk("hold_valid", 64'(noc_valid), 64'd1);
            chk("hold_flit", 64'(noc_flit), 64'(prev_flit));
         end
         if (noc_valid && !noc_ready) begin
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_word_ready", 64'(word_ready), 64'd0);
         end
         if (noc_valid && noc_ready) begin
            if (exp_q.size() == 0) chk("extra_flit", 64'(noc_flit), 64'h3_0000_0000_0);
            else chk("flit_stream", 64'(noc_flit), 64'(exp_q.pop_front()));
         end
         if (err_len) obs_err++;
         stall_prev = noc_valid && !noc_ready;
         prev_flit  = noc_flit;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Builds the expected flits of one request, then drives it under rmode.
   task automatic drive_pkt(input logic [4:0] d, input logic [2:0] c, input int l);
      logic [31:0] w[$];
      logic        hs;
      int          i, k;
      if (l > MAX_LEN) exp_err++;
      else begin
         for (int j = 0; j < l; j++) w.push_back($urandom);
         exp_q.push_back(head((l == 0) ? 2'b11 : 2'b01, d, c));
         for (int j = 0; j < l; j++) exp_q.push_back({(j == l - 1) ? 2'b10 : 2'b00, w[j]});
      end
      req_valid = 1'b1; req_dest = d; req_class = c; req_len = LW'(l);
      hs = 1'b0;
      for (int t = 0; t < 100 && !hs; t++) begin
         #1 hs = req_ready;
         step_r();
      end
      req_valid = 1'b0;
      if (!hs) begin
         chk("req_timeout", 64'd0, 64'd1);
         return;
      end
      i = 0; k = 0;
      while (l <= MAX_LEN && i < l && k < 400) begin
         word_valid = ($urandom_range(0, 3) != 0);
         word_data  = word_valid ? w[i] : 32'hDEAD_BEEF;
         #1 hs = word_valid && word_ready;
         step_r();
         if (hs) i++;
         k++;
      end
      word_valid = 1'b0;
      if (l <= MAX_LEN && i < l) chk("word_timeout", 64'(i), 64'(l));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [4:0]  dest;
      logic [2:0]  cls;
      logic [4:0]  len;
      logic        err;
      logic [33:0] exp_head;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      noc_ready = 1'b1;
      req_valid = 1'b1; req_dest = v.dest; req_class = v.cls; req_len = v.len;
      #1 chk("vec_req_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      if (v.err) begin
         #1 chk("vec_err_pulse", 64'(err_len), 64'd1);
         chk("vec_err_novalid", 64'(noc_valid), 64'd0);
         step();
         #1 chk("vec_err_drop", 64'(err_len), 64'd0);
         chk("vec_err_novalid2", 64'(noc_valid), 64'd0);
         chk("vec_err_busy", 64'(busy), 64'd0);
      end else begin
         #1 chk("vec_head", 64'(noc_flit), 64'(v.exp_head));
         chk("vec_head_valid", 64'(noc_valid), 64'd1);
         for (int i = 0; i < int'(v.len); i++) begin
            word_valid = 1'b1; word_data = 32'hA0 + 32'(i);
            #1 chk("vec_word_ready", 64'(word_ready), 64'd1);
            step();
            word_valid = 1'b0;
            #1 chk("vec_word", 64'(noc_flit),
                   64'({(i == int'(v.len) - 1) ? 2'b10 : 2'b00, 32'hA0 + 32'(i)}));
         end
         if (v.len == 0) begin
            word_valid = 1'b1; word_data = 32'h1234_5678;
            #1 chk("vec_idle_word_ready", 64'(word_ready), 64'd0);
         end
         step();
         word_valid = 1'b0;
         #1 chk("vec_drained", 64'(noc_valid), 64'd0);
         chk("vec_busy", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{5'd3,  3'd1, 5'd2,  1'b0, 34'h1_1928_0000};
      vecs[1] = '{5'd31, 3'd7, 5'd0,  1'b0, 34'h3_FF28_0000};
      vecs[2] = '{5'd0,  3'd0, 5'd1,  1'b0, 34'h1_0028_0000};
      vecs[3] = '{5'd17, 3'd2, 5'd16, 1'b0, 34'h1_8A28_0000};
      vecs[4] = '{5'd5,  3'd3, 5'd17, 1'b1, 34'h0};
      vecs[5] = '{5'd9,  3'd4, 5'd31, 1'b1, 34'h0};

      rst = 1'b1; req_valid = 1'b0; req_dest = '0; req_class = '0; req_len = '0;
      word_valid = 1'b0; word_data = '0; noc_ready = 1'b1;
      step();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_word_ready", 64'(word_ready), 64'd0);
      chk("rst_noc_valid", 64'(noc_valid), 64'd0);
      chk("rst_noc_flit", 64'(noc_flit), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err_len", 64'(err_len), 64'd0);
      rst = 1'b0;
      #1 chk("post_rst_req_ready", 64'(req_ready), 64'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // back-to-back len=1 packets: HEAD, LAST, HEAD, LAST with no gap
      noc_ready = 1'b1;
      req_valid = 1'b1; req_dest = 5'd1; req_class = 3'd1; req_len = 5'd1;
      step();
      req_valid = 1'b0;
      #1 chk("b2b_head1", 64'(noc_flit), 64'(head(2'b01, 5'd1, 3'd1)));
      word_valid = 1'b1; word_data = 32'h11;
      step();
      word_valid = 1'b0;
      req_valid = 1'b1; req_dest = 5'd2; req_class = 3'd2; req_len = 5'd1;
      #1 chk("b2b_last1", 64'(noc_flit), 64'({2'b10, 32'h11}));
      chk("b2b_req_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      #1 chk("b2b_head2", 64'(noc_flit), 64'(head(2'b01, 5'd2, 3'd2)));
      chk("b2b_valid", 64'(noc_valid), 64'd1);
      word_valid = 1'b1; word_data = 32'h22;
      step();
      word_valid = 1'b0;
      #1 chk("b2b_last2", 64'(noc_flit), 64'({2'b10, 32'h22}));
      step();
      #1 chk("b2b_drained", 64'(busy), 64'd0);

      // reset after 2 of 5 payload words
      req_valid = 1'b1; req_dest = 5'd4; req_class = 3'd2; req_len = 5'd5;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         word_valid = 1'b1; word_data = 32'hC0 + 32'(i);
         step();
      end
      word_valid = 1'b0;
      #1 chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1 chk("mid_rst_word_ready", 64'(word_ready), 64'd0);
      step();
      rst = 1'b0;
      #1 chk("mid_rst_valid", 64'(noc_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
      word_valid = 1'b1; word_data = 32'hBAD;
      #1 chk("mid_rst_word_ignored", 64'(word_ready), 64'd0);
      word_valid = 1'b0;
      req_valid = 1'b1; req_dest = 5'd2; req_class = 3'd0; req_len = 5'd1;
      step();
      req_valid = 1'b0;
      #1 chk("mid_rst_new_head", 64'(noc_flit), 64'h1_1028_0000);
      word_valid = 1'b1; word_data = 32'h55;
      step();
      word_valid = 1'b0;
      #1 chk("mid_rst_new_last", 64'(noc_flit), 64'({2'b10, 32'h55}));
      step();

      // len=4 with noc_ready toggling every cycle, then randomized traffic
      mon_en = 1'b1;
      rmode = 1;
      noc_ready = 1'b1;
      drive_pkt(5'd6, 3'd5, 4);
      rmode = 2;
      for (int p = 0; p < 40; p++) begin
         drive_pkt(5'($urandom), 3'($urandom), int'($urandom_range(0, MAX_LEN + 3)));
         if ($urandom_range(0, 2) == 0) begin
            word_valid = 1'b1; word_data = 32'hFFFF_0000;
            #1 if (!busy || !word_ready) chk("idle_word_ready", 64'(word_ready), 64'd0);
            step_r();
            word_valid = 1'b0;
         end
      end
      rmode = 0;
      for (int k = 0; k < 100; k++) begin
         step_r();
         if (!busy) break;
      end
      step();
      mon_en = 1'b0;
      chk("final_idle", 64'(busy), 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("err_count", 64'(obs_err), 64'(exp_err));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
